// File: rtl/uart_pkg.sv
// Shared UART encodings: frame-format fields, transmit FSM states and the
// latched per-frame configuration.
package uart_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [1:0] {
      PARITY_NONE     = 2'b00,
      PARITY_ODD      = 2'b01,
      PARITY_EVEN     = 2'b10,
      PARITY_NONE_ALT = 2'b11
   } parity_e;

   typedef enum logic {
      LEN_7 = 1'b0,
      LEN_8 = 1'b1
   } length_e;

   typedef enum logic {
      STOP_1 = 1'b0,
      STOP_2 = 1'b1
   } stop_e;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_ARM    = 3'd1,
      TX_START  = 3'd2,
      TX_DATA   = 3'd3,
      TX_PARITY = 3'd4,
      TX_STOP   = 3'd5
   } tx_state_e;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      length_e           length;
      parity_e           parity;
      stop_e             stop;
   } tx_cfg_t;

   function automatic logic parity_enabled(input parity_e p);
      return (p == PARITY_ODD) || (p == PARITY_EVEN);
   endfunction

endpackage

// File: rtl/uart_parity.sv
// Combinational parity generator for a 7/8-bit UART character; also used
// by the receive side for checking.
module uart_parity
   import uart_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   input  length_e           length_i,
   input  parity_e           type_i,
   output logic              parity_o
);

   logic [DATA_W-1:0] masked;
   logic              xor_bits;

   // In 7-bit mode the MSB is not part of the character.
   always_comb begin
      masked = data_i;
      if (length_i == LEN_7) begin
         masked[DATA_W-1] = 1'b0;
      end
      xor_bits = ^masked;
      case (type_i)
         PARITY_ODD:  parity_o = ~xor_bits;
         PARITY_EVEN: parity_o = xor_bits;
         default:     parity_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: turns baud_clk rising edges into bit ticks and
// serialises a latched byte as start/data/parity/stop onto tx.
module uart_tx_frame
   import uart_pkg::*;
(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              baud_clk,
   input  logic              send,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_length,
   input  logic [1:0]        parity_type,
   input  logic              stop_bits,
   output logic              tx,
   output logic              busy,
   output logic              done
);

   tx_state_e        state_q, state_d;
   tx_cfg_t          cfg_q, cfg_d;
   logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
   logic             stop_cnt_q, stop_cnt_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             baud_q;

   logic             tick;
   logic             parity_bit;
   logic [CNT_W-1:0] last_idx;

   // baud_clk comes from the same clock domain, so a plain edge detect suffices.
   assign tick     = baud_clk & ~baud_q;
   assign last_idx = (cfg_q.length == LEN_8) ? CNT_W'(7) : CNT_W'(6);

   uart_parity u_parity (
      .data_i   (cfg_q.data),
      .length_i (cfg_q.length),
      .type_i   (cfg_q.parity),
      .parity_o (parity_bit)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= TX_IDLE;
         cfg_q      <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         baud_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cfg_q      <= cfg_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         baud_q     <= baud_clk;
      end
   end

   // Next-state logic; tx_d is the level for the bit period starting at this tick.
   always_comb begin
      state_d    = state_q;
      cfg_d      = cfg_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      tx_d       = tx_q;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         TX_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (send) begin
               cfg_d.data   = data_in;
               cfg_d.length = length_e'(data_length);
               cfg_d.parity = parity_e'(parity_type);
               cfg_d.stop   = stop_e'(stop_bits);
               busy_d       = 1'b1;
               state_d      = TX_ARM;
            end
         end

         TX_ARM: begin
            if (tick) begin
               tx_d    = 1'b0;
               state_d = TX_START;
            end
         end

         TX_START: begin
            if (tick) begin
               tx_d      = cfg_q.data[0];
               bit_cnt_d = '0;
               state_d   = TX_DATA;
            end
         end

         TX_DATA: begin
            if (tick) begin
               if (bit_cnt_q == last_idx) begin
                  if (parity_enabled(cfg_q.parity)) begin
                     tx_d    = parity_bit;
                     state_d = TX_PARITY;
                  end else begin
                     tx_d       = 1'b1;
                     stop_cnt_d = cfg_q.stop;
                     state_d    = TX_STOP;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + CNT_W'(1);
                  tx_d      = cfg_q.data[bit_cnt_q + CNT_W'(1)];
               end
            end
         end

         TX_PARITY: begin
            if (tick) begin
               tx_d       = 1'b1;
               stop_cnt_d = cfg_q.stop;
               state_d    = TX_STOP;
            end
         end

         TX_STOP: begin
            tx_d = 1'b1;
            if (tick) begin
               if (stop_cnt_q == 1'b0) begin
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  state_d = TX_IDLE;
               end else begin
                  stop_cnt_d = 1'b0;
               end
            end
         end

         default: begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            state_d = TX_IDLE;
         end
      endcase
   end

   assign tx   = tx_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: hand-built frames sampled mid-bit with a
// 16-clock bit period, plus reset, back-to-back, ignored-send and stall cases.
module tb_uart_tx_frame;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       baud_clk = 1'b0;
   logic       send;
   logic [7:0] data_in;
   logic       data_length;
   logic [1:0] parity_type;
   logic       stop_bits;
   logic       tx;
   logic       busy;
   logic       done;

   logic [3:0] baud_cnt = 4'd0;
   logic       baud_en  = 1'b1;

   int n_vec = 0;
   int n_err = 0;
   int gap;

   uart_tx_frame dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .baud_clk    (baud_clk),
      .send        (send),
      .data_in     (data_in),
      .data_length (data_length),
      .parity_type (parity_type),
      .stop_bits   (stop_bits),
      .tx          (tx),
      .busy        (busy),
      .done        (done)
   );

   always #5 clock = ~clock;

   // One baud_clk rising edge every 16 clocks; freezes while baud_en is low.
   always @(negedge clock) begin
      if (baud_en) begin
         baud_cnt <= baud_cnt + 4'd1;
         baud_clk <= ~(baud_cnt + 4'd1) >> 3 == 4'd1 ? 1'b1 : 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input logic len,
                             input logic [1:0] par, input logic stp);
      @(negedge clock);
      data_in     = d;
      data_length = len;
      parity_type = par;
      stop_bits   = stp;
      send        = 1'b1;
      @(negedge clock);
      send = 1'b0;
      chk("accept_busy", 32'(busy), 32'(1'b1));
   endtask

   // exp[i] is frame bit i (bit 0 = start). Optionally stalls baud for 500
   // clocks after bit stall_bit, and issues a back-to-back send in the done cycle.
   task automatic check_frame(input string tag, input logic [15:0] exp, input int nbits,
                              input int stall_bit, input bit b2b, output int wait_cnt);
      int w;
      w = 0;
      do begin
         @(negedge clock);
         w++;
      end while (tx !== 1'b0 && w < 40);
      wait_cnt = w;
      chk({tag, "_start"}, 32'(tx), 32'(1'b0));
      if (tx !== 1'b0) return;
      for (int i = 0; i < nbits; i++) begin
         repeat ((i == 0) ? 8 : 16) @(negedge clock);
         chk($sformatf("%s_bit%0d", tag, i), 32'(tx), 32'(exp[i]));
         if (i == stall_bit) begin
            #1 baud_en = 1'b0;
            for (int j = 0; j < 5; j++) begin
               repeat (100) @(negedge clock);
               chk($sformatf("%s_stall_tx%0d", tag, j), 32'(tx), 32'(exp[i]));
               chk($sformatf("%s_stall_busy%0d", tag, j), 32'(busy), 32'(1'b1));
            end
            #1 baud_en = 1'b1;
         end
      end
      repeat (7) @(negedge clock);
      chk({tag, "_pre_done"}, 32'(done), 32'(1'b0));
      chk({tag, "_pre_busy"}, 32'(busy), 32'(1'b1));
      @(negedge clock);
      chk({tag, "_done"}, 32'(done), 32'(1'b1));
      chk({tag, "_done_busy"}, 32'(busy), 32'(1'b0));
      chk({tag, "_done_tx"}, 32'(tx), 32'(1'b1));
      if (b2b) begin
         data_in     = 8'hC3;
         data_length = 1'b1;
         parity_type = 2'b10;
         stop_bits   = 1'b0;
         send        = 1'b1;
      end
      @(negedge clock);
      send = 1'b0;
      chk({tag, "_post_done"}, 32'(done), 32'(1'b0));
   endtask

   initial begin
      int w;
      reset_n     = 1'b0;
      send        = 1'b0;
      data_in     = 8'h00;
      data_length = 1'b1;
      parity_type = 2'b00;
      stop_bits   = 1'b0;

      repeat (3) @(negedge clock);
      chk("rst_tx", 32'(tx), 32'(1'b1));
      chk("rst_busy", 32'(busy), 32'(1'b0));
      chk("rst_done", 32'(done), 32'(1'b0));
      reset_n = 1'b1;
      repeat (5) @(negedge clock);

      // A5, 8N1: 0,1,0,1,0,0,1,0,1,1
      send_frame(8'hA5, 1'b1, 2'b00, 1'b0);
      check_frame("a5_8n1", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, -1, 1'b0, gap);

      // 03, 8 bits, odd parity (two ones -> parity 1), two stop bits
      send_frame(8'h03, 1'b1, 2'b01, 1'b1);
      check_frame("03_8o2", {4'b0, 2'b11, 1'b1, 8'h03, 1'b0}, 12, -1, 1'b0, gap);

      // FF, 7 bits, even parity (seven ones -> parity 1), one stop bit
      send_frame(8'hFF, 1'b0, 2'b10, 1'b0);
      check_frame("ff_7e1", {6'b0, 1'b1, 1'b1, 7'h7F, 1'b0}, 10, -1, 1'b0, gap);

      // 5A 8N1 with an ignored mid-frame send; C3 8E1 sent in the done cycle
      send_frame(8'h5A, 1'b1, 2'b00, 1'b0);
      fork
         check_frame("5a_8n1", {6'b0, 1'b1, 8'h5A, 1'b0}, 10, -1, 1'b1, gap);
         begin
            repeat (40) @(negedge clock);
            data_in     = 8'h00;
            data_length = 1'b0;
            parity_type = 2'b01;
            stop_bits   = 1'b1;
            send        = 1'b1;
            @(negedge clock);
            send = 1'b0;
         end
      join
      // C3 has four ones -> even parity 0
      check_frame("c3_8e1", {5'b0, 1'b1, 1'b0, 8'hC3, 1'b0}, 11, -1, 1'b0, gap);
      // Start bit one bit period after done (one negedge already consumed in the done task).
      chk("b2b_gap", 32'(gap), 32'd15);
      repeat (48) @(negedge clock);
      chk("idle_after_b2b_busy", 32'(busy), 32'(1'b0));
      chk("idle_after_b2b_tx", 32'(tx), 32'(1'b1));

      // Reset during data bit 3 of F0 (that bit is 0)
      send_frame(8'hF0, 1'b1, 2'b00, 1'b0);
      w = 0;
      do begin
         @(negedge clock);
         w++;
      end while (tx !== 1'b0 && w < 40);
      chk("f0_start", 32'(tx), 32'(1'b0));
      repeat (16 * 4 + 6) @(negedge clock);
      chk("f0_bit3", 32'(tx), 32'(1'b0));
      chk("f0_busy", 32'(busy), 32'(1'b1));
      #1 reset_n = 1'b0;
      #1;
      chk("midrst_tx", 32'(tx), 32'(1'b1));
      chk("midrst_busy", 32'(busy), 32'(1'b0));
      chk("midrst_done", 32'(done), 32'(1'b0));
      repeat (3) @(negedge clock);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
      send_frame(8'h3C, 1'b1, 2'b00, 1'b0);
      check_frame("3c_after_rst", {6'b0, 1'b1, 8'h3C, 1'b0}, 10, -1, 1'b0, gap);

      // 96 8N1 with baud_clk frozen for 500 clocks during data bit 1
      send_frame(8'h96, 1'b1, 2'b00, 1'b0);
      check_frame("96_stall", {6'b0, 1'b1, 8'h96, 1'b0}, 10, 2, 1'b0, gap);

      repeat (20) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- UART transmit framer, directly downstream of the baud generator, in the system `clock` domain.
- Samples `baud_clk`, detects its rising edges (bit ticks), and serialises a latched byte onto `tx`: start bit, 7/8 data bits LSB first, optional parity, 1/2 stop bits.
- Provides a send/busy/done handshake to the host-side logic.

Parameters:
none (frame format is selected per frame through ports)

Ports:
clock        input   1  system clock; same clock that drives the baud generator
reset_n      input   1  asynchronous, active-low reset
baud_clk     input   1  baud generator output; one rising edge per bit period
send         input   1  request; sampled only in IDLE
data_in      input   8  byte to transmit; latched on accept
data_length  input   1  0 = 7 data bits, 1 = 8 data bits; latched on accept
parity_type  input   2  00/11 = none, 01 = odd, 10 = even; latched on accept
stop_bits    input   1  0 = one stop bit, 1 = two stop bits; latched on accept
tx           output  1  serial line, idle high, registered
busy         output  1  high from the cycle after accept until the frame completes
done         output  1  one-cycle pulse after the last stop bit

Behaviour:
- Reset, asynchronous, active-low: `reset_n` low forces state = IDLE, `tx` = 1, `busy` = 0, `done` = 0, bit/stop counters = 0, and `baud_q` (registered copy of `baud_clk`) = 0.
  - Reset asserted mid-frame aborts the frame; `tx` returns high immediately.
- Bit tick: `tick` = `baud_clk` & ~`baud_q`.
  - `baud_clk` is generated in the `clock` domain, so no synchroniser is used.
  - One bit period is rising edge to rising edge.
- State machine states: IDLE, ARM, START, DATA, PARITY, STOP.
  - IDLE: `tx` = 1, `busy` = 0. When `send` = 1, latch `data_in`, `data_length`, `parity_type`, `stop_bits`; go to ARM; `busy` = 1 from the next cycle.
  - ARM: wait for `tick`. On `tick`, go to START; `tx` = 0 from the next cycle.
  - START: on `tick`, go to DATA; `tx` = d[0]; bit counter = 0.
  - DATA: on `tick`, if counter = last index (6 or 7), go to PARITY when parity is enabled, else STOP; otherwise increment the counter and drive `tx` = d[counter+1].
  - PARITY: `tx` = parity bit. On `tick`, go to STOP.
  - STOP: `tx` = 1. On `tick`, if remaining stop bits = 0, go to IDLE and pulse `done`; otherwise decrement.
- Timing: every bit is held exactly one bit period. Latency from accept to start-bit edge is up to one bit period.
- Parity:
  - Even parity bit = XOR of the transmitted data bits.
  - Odd parity bit = inverse of that XOR.
  - In 7-bit mode, d[7] is excluded from both the data and the parity calculation.
- Handshake:
  - `send` while `busy` is ignored; no queueing.
  - The latched fields are stable for the whole frame; changes on the inputs mid-frame have no effect.
- Completion: `done` is high in the first IDLE cycle and `busy` is 0 in that cycle.
  - `send` = 1 in that same cycle is accepted, giving back-to-back frames with no extra idle bit.
- Stalled baud clock: if `baud_clk` stops, the FSM holds its state and `tx` indefinitely; no timeout.
- `baud_clk` high at reset release: `baud_q` = 0, so a tick is possible in the first cycle. It is harmless in IDLE.

Decomposition:
- Shared package `uart_pkg`:
  - parity encodings (`PARITY_NONE`, `PARITY_ODD`, `PARITY_EVEN`)
  - stop/length encodings
  - TX state enum
- One natural sub-module: `uart_parity`, combinational, taking data, length and type and producing the parity bit. The Rx side reuses it for checking.

Test Plan:
- Bench `baud_clk` rising every 16 clocks. `data_in` = 8'hA5, 8-bit, no parity, 1 stop, `send` pulse -> `tx` = 0,1,0,1,0,0,1,0,1,1, each bit 16 clocks; `done` pulses once; `busy` falls with `done`.
- 8'h03, 8-bit, odd parity, 2 stop -> parity bit 1, then two 16-clock stop bits; frame length 12 bit periods.
- 8'hFF, 7-bit, even parity -> 7 ones, parity 1, d[7] never appears on `tx`; frame length 10 bit periods.
- `send` re-asserted mid-frame with 8'h00 -> ignored; the original frame completes unchanged. `send` in the `done` cycle -> next start bit at the following tick.
- `reset_n` low during data bit 3 -> `tx` = 1, `busy` = 0 immediately. After release, a new `send` produces a clean frame.
- `baud_clk` held constant for 500 clocks during DATA -> `tx` is frozen and no state advance occurs; transmission resumes on the next rising edge.
